// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the memory stage, the DMA/program loader, the data memory
// and dmem_arbiter.
//   slave  : arbiter side (takes core/dma requests, drives the memory port)
//   master : environment side (requesters and memory model)
// Signals:
//   core_req/we/addr/wdata, core_stall, core_rvalid, core_rdata : core port
//   dma_req/we/lock/addr/wdata, dma_gnt, dma_rvalid, dma_rdata   : dma port
//   mem_en/we/addr/wdata, mem_rdata                              : memory port
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    logic          dma_req;
    logic          dma_we;
    logic          dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  mem_rdata,
        output core_stall, core_rvalid, core_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output mem_rdata,
        input  core_stall, core_rvalid, core_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: one access per cycle shared between the pipeline memory
// stage (core) and the DMA/program loader (dma).
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : dmem_arbiter_if.slave (core port, dma port, memory port)
// Core normally wins; DMA is forced through after STARVE_MAX contended core
// grants, and may take burst ownership (DMA_LOCK) for up to LOCK_MAX grants.
// Read data returns one cycle after issue, steered by a registered tag.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic {CORE_PRI, DMA_LOCK} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_DMA} tag_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] LOCK_LIM   = 4'(LOCK_MAX);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic [3:0] lock_q, lock_d;
    tag_e       tag_q, tag_d;

    logic core_win, dma_win;

    // Grants are masked while reset is held so the memory port stays idle.
    always_comb begin
        dma_win = 1'b0;
        if (state_q == DMA_LOCK)
            dma_win = bus.dma_req;
        else
            dma_win = bus.dma_req && (!bus.core_req || starve_q == STARVE_LIM);
        dma_win  = dma_win & rst;
        core_win = bus.core_req & ~dma_win & rst;
    end

    assign bus.core_stall = bus.core_req & ~core_win & rst;
    assign bus.dma_gnt    = dma_win;
    assign bus.mem_en     = core_win | dma_win;
    assign bus.mem_we     = (core_win & bus.core_we) | (dma_win & bus.dma_we);
    assign bus.mem_addr   = core_win ? bus.core_addr  : (dma_win ? bus.dma_addr  : '0);
    assign bus.mem_wdata  = core_win ? bus.core_wdata : (dma_win ? bus.dma_wdata : '0);

    assign bus.core_rvalid = (tag_q == TAG_CORE);
    assign bus.dma_rvalid  = (tag_q == TAG_DMA);
    assign bus.core_rdata  = (tag_q == TAG_CORE) ? bus.mem_rdata : '0;
    assign bus.dma_rdata   = (tag_q == TAG_DMA)  ? bus.mem_rdata : '0;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        lock_d   = lock_q;

        if (core_win && !bus.core_we)
            tag_d = TAG_CORE;
        else if (dma_win && !bus.dma_we)
            tag_d = TAG_DMA;
        else
            tag_d = TAG_NONE;

        case (state_q)
            CORE_PRI: begin
                if (dma_win) begin
                    starve_d = '0;
                    if (bus.dma_lock) begin
                        state_d = DMA_LOCK;
                        lock_d  = 4'd1;
                    end
                end else if (core_win && bus.dma_req) begin
                    if (starve_q != STARVE_LIM)
                        starve_d = starve_q + 4'd1;
                end else if (!bus.dma_req) begin
                    starve_d = '0;
                end
            end
            DMA_LOCK: begin
                starve_d = '0;
                if (!dma_win) begin
                    state_d = CORE_PRI;
                    lock_d  = '0;
                end else if (!bus.dma_lock || (lock_q + 4'd1) >= LOCK_LIM) begin
                    // This grant is the last of the burst; it still completes.
                    state_d = CORE_PRI;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + 4'd1;
                end
            end
            default: begin
                state_d  = CORE_PRI;
                starve_d = '0;
                lock_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CORE_PRI;
            starve_q <= '0;
            lock_q   <= '0;
            tag_q    <= TAG_NONE;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            tag_q    <= tag_d;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between the pipeline memory stage (core port) and a DMA/program-loader port (dma port). Grants at most one access per cycle, stalls the losing core request, and enforces a starvation bound on DMA. Routes read data back to the issuing requester one cycle after issue. Sits between the memory stage and the data memory instance.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, consecutive core grants tolerated while dma_req is pending before DMA is forced through (range 1..15)
LOCK_MAX, 8, maximum consecutive DMA grants in LOCK state before ownership returns to core (range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  memory stage requests access this cycle
core_we  in  1  1 = write, 0 = read
core_addr  in  AW  core byte address
core_wdata  in  DW  core write data
core_stall  out  1  core_req present but not granted; pipeline holds MEM stage
core_rvalid  out  1  core read data valid this cycle
core_rdata  out  DW  core read data
dma_req  in  1  DMA requests access; must hold req/we/addr/wdata stable until dma_gnt
dma_we  in  1  1 = write, 0 = read
dma_lock  in  1  DMA requests burst ownership (sampled on a granted DMA access)
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access accepted this cycle (combinational)
dma_rvalid  out  1  DMA read data valid this cycle
dma_rdata  out  DW  DMA read data
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address (muxed)
mem_wdata  out  DW  memory write data (muxed)
mem_rdata  in  DW  memory read data, synchronous, valid cycle after read issue

Behaviour:
- States: CORE_PRI (core default winner), DMA_LOCK (DMA default winner). Reset state CORE_PRI.
- Grant in CORE_PRI: dma wins if dma_req && (!core_req || starve_cnt == STARVE_MAX); else core wins if core_req.
- Grant in DMA_LOCK: dma wins if dma_req; else core wins if core_req.
- Combinational outputs: core_stall = core_req & ~core_win; dma_gnt = dma_win; mem_en = core_win | dma_win; mem_we/addr/wdata from winner, all zero when no winner.
- starve_cnt (4-bit): CORE_PRI only. +1 (saturating at STARVE_MAX) on cycle core wins while dma_req high; cleared when dma wins or dma_req low; cleared on entry to DMA_LOCK.
- lock_cnt (4-bit): CORE_PRI -> DMA_LOCK when dma wins with dma_lock=1; lock_cnt set to 1. In DMA_LOCK, each dma win increments lock_cnt.
- DMA_LOCK -> CORE_PRI on any of: dma_lock=0 at a dma win (that access still completes), dma_req=0 for a cycle, or dma win with lock_cnt == LOCK_MAX. lock_cnt cleared on exit.
- Read return: 2-bit tag register rd_tag {NONE, CORE, DMA} loaded each cycle with winner if read, NONE otherwise. Cycle after issue: core_rvalid / dma_rvalid = 1 per tag, rdata = mem_rdata; non-selected rdata = 0. Writes never produce rvalid. Read latency exactly 1 cycle; back-to-back reads every cycle supported.
- Reset (async assert): state CORE_PRI, starve_cnt=0, lock_cnt=0, rd_tag=NONE; core_rvalid=dma_rvalid=0, rdata outputs 0. Reset mid-read drops the pending rvalid; no data returned after release.
- No requests: mem_en=0, counters hold except starve_cnt clears (dma_req low).
- Simultaneous write/read address collision across ports is impossible (one grant per cycle).

Test Plan:
- Reset with core_req=1: all outputs 0 during rst=0; after release, core read of 0x10 -> mem_en=1, core_stall=0, next cycle core_rvalid=1, core_rdata = mem_rdata.
- core_req and dma_req held high continuously, STARVE_MAX=4, dma_lock=0 -> core wins 4 cycles, dma_gnt on 5th with core_stall=1 that cycle, pattern repeats every 5 cycles.
- Core idle, DMA writes 0xA5A5A5A5 to 0x40 then reads 0x40 -> dma_gnt both cycles, mem_we=1 then 0, dma_rvalid=1 one cycle after read with data 0xA5A5A5A5, core_rvalid stays 0.
- dma_lock=1, dma_req held, core_req held, LOCK_MAX=8 -> 8 consecutive dma_gnt with core_stall=1, then core wins next cycle; dropping dma_lock at 3rd grant returns to CORE_PRI after that grant.
- Alternating core read / dma read each cycle -> rvalids alternate, each tagged to correct port, no lost or duplicated rvalid.
- rst asserted the cycle after a core read issue -> core_rvalid never asserts; after release starve_cnt=0 (first contended cycle goes to core).
